// File: rtl/lab3_defs_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width and FSM state encodings.
package lab3_defs;

    localparam int unsigned NIBBLE_W = 4;

    // Encoding 2'd3 is unreachable and is treated as IDLE by the control logic.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lab3_nibble_serial_adder_cla.sv
// Combinational 4-bit carry-lookahead slice.
// Optional macro LAB3_SERIAL_ADDER_OVF_EN exposes the carry into bit 3.
module lab3_nibble_cla
    import lab3_defs::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_cout
`ifdef LAB3_SERIAL_ADDER_OVF_EN
    ,
    output logic                o_c3
`endif
);

    logic [NIBBLE_W-1:0] w_p;
    logic [NIBBLE_W-1:0] w_g;
    logic [NIBBLE_W:0]   w_c;

    // Propagate/generate terms and two-level lookahead carries.
    always_comb begin
        w_p    = i_a ^ i_b;
        w_g    = i_a & i_b;
        w_c[0] = i_cin;
        w_c[1] = w_g[0] | (w_p[0] & i_cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & i_cin);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);
        o_sum  = w_p ^ w_c[NIBBLE_W-1:0];
        o_cout = w_c[4];
    end

`ifdef LAB3_SERIAL_ADDER_OVF_EN
    assign o_c3 = w_c[3];
`endif

endmodule

// File: rtl/lab3_nibble_serial_adder.sv
// WIDTH-bit adder that resolves one nibble per clock through a shared CLA slice.
// Optional macro LAB3_SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module lab3_nibble_serial_adder
    import lab3_defs::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef LAB3_SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int unsigned NIBBLES  = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e              r_state;
    state_e              w_next;
    logic                w_accept;
    logic                w_step;
    logic                w_last;

    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_sum;
    logic                r_carry;
    logic [IDX_W-1:0]    r_idx;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_nib_sum;
    logic                w_nib_cout;
`ifdef LAB3_SERIAL_ADDER_OVF_EN
    logic                w_c3;
    logic                r_ovf;
`endif

    // Select the operand nibbles addressed by the current index.
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_nib = r_a[i*NIBBLE_W +: NIBBLE_W];
                w_b_nib = r_b[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    lab3_nibble_cla u_cla (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
`ifdef LAB3_SERIAL_ADDER_OVF_EN
        .o_c3   (w_c3),
`endif
        .o_cout (w_nib_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath strobes; the unused encoding behaves as IDLE.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_last   = (r_idx == LAST_IDX);
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_RUN;
                end else begin
                    w_next   = ST_IDLE;
                end
            end
        endcase
    end

    // Operand capture on accept, one nibble of sum and carry per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
`ifdef LAB3_SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_carry <= cin;
            r_idx   <= '0;
`ifdef LAB3_SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_step) begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_sum[i*NIBBLE_W +: NIBBLE_W] <= w_nib_sum;
                end
            end
            r_carry <= w_nib_cout;
            r_idx   <= r_idx + IDX_W'(1);
`ifdef LAB3_SERIAL_ADDER_OVF_EN
            if (w_last) begin
                r_ovf <= w_c3 ^ w_nib_cout;
            end
`endif
        end
    end

    // Handshake and status outputs decode the state register only.
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign in_ready  = !busy;
    assign sum       = r_sum;
    assign cout      = out_valid & r_carry;
`ifdef LAB3_SERIAL_ADDER_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_lab3_nibble_serial_adder.sv
// Scoreboard bench for lab3_nibble_serial_adder (WIDTH=16).
// Define LAB3_SERIAL_ADDER_OVF_EN to also check the ovf output.
module tb_lab3_nibble_serial_adder;

    localparam int unsigned W = 16;
    localparam int LATENCY = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef LAB3_SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    lab3_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef LAB3_SERIAL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;
    exp_t sb[$];

    bit rand_ready = 1'b0;
    bit seen = 1'b0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference: plain unsigned addition, signed overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int acc);
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        e.acc  = acc;
        return e;
    endfunction

    // Present operands until accepted; push the expected result if asked.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit push);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
        for (int n = 0; n < 200; n++) begin
            if (in_ready) begin
                tick();
                got = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready never high for %0h+%0h", x, y);
        end else if (push) begin
            sb.push_back(model(x, y, c, cyc));
        end
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom_range(0, 1));
    endtask

    // Let every outstanding result drain with out_ready held high.
    task automatic drain();
        bit done;
        done = 1'b0;
        rand_ready = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
        end
    endtask

    // Monitor: compare each result on the first cycle it is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out_valid: sum=%0h at cycle %0d", sum, cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        check("sum", 32'(sum), 32'(mon_e.sum));
                        check("cout", 32'(cout), 32'(mon_e.cout));
`ifdef LAB3_SERIAL_ADDER_OVF_EN
                        check("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
                        check("latency", 32'(cyc - mon_e.acc), 32'(LATENCY));
                    end
                end
                if (out_ready) seen = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        // Reset state.
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef LAB3_SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;

        // Directed arithmetic cases.
        send(16'h1234, 16'h4321, 1'b0, 1'b1);
        drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        drain();
        send(16'h0000, 16'h0000, 1'b1, 1'b1);
        drain();

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        send(16'h00FF, 16'h0001, 1'b0, 1'b1);
        hit = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (out_valid) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("bp_out_valid_seen", 32'(hit), 32'd1);
        for (int n = 0; n < 5; n++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum), 32'h0100);
            check("bp_cout", 32'(cout), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Reset during the second RUN cycle aborts the operation.
        send(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("abort_idle_in_ready", 32'(in_ready), 32'd1);
        send(16'h0001, 16'h0001, 1'b0, 1'b1);
        drain();

`ifdef LAB3_SERIAL_ADDER_OVF_EN
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        drain();
`endif

        // Random operands with random backpressure, back-to-back issue.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        send(16'h8000, 16'h8000, 1'b0, 1'b1);
        drain();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lab3_nibble_serial_adder.md
# lab3_nibble_serial_adder

Multi-cycle WIDTH-bit adder that processes one 4-bit nibble per clock through a 4-bit carry-lookahead slice. It carries the ripple between nibbles in a register.
- Upstream: operand source, via a valid/ready handshake.
- Downstream: result consumer, via a valid/ready handshake.
- It reuses the 4-bit CLA datapath so wide additions cost no extra adder area.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.

Ports (reset is asynchronous and active-low):
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a/b/cin valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  addend A
- b  input  WIDTH  addend B
- cin  input  1  carry into bit 0
- out_valid  output  1  sum/cout valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  A+B+cin, low WIDTH bits
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  high in RUN or DONE

## Operation
- NIBBLES = WIDTH/4. Nibble index register is $clog2(NIBBLES) bits wide, minimum 1.
- FSM has states IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b; carry_reg<=cin; idx<=0; sum register cleared; go to RUN.
- RUN:
  - Each cycle, the CLA slice adds a[4*idx+:4], b[4*idx+:4] and carry_reg.
  - Result nibble is written to sum[4*idx+:4]; carry_reg<=slice carry out; idx<=idx+1.
  - When idx==NIBBLES-1, the write completes and the FSM goes to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1; cout=carry_reg.
  - sum, cout and out_valid are held stable until out_ready is sampled high. Then go to IDLE.
  - in_ready=0 in DONE, including the cycle out_ready is high. No accept-on-drain.
- Operand inputs are ignored outside the IDLE accept cycle. Changes to a/b during RUN have no effect.
- in_valid may be asserted while busy. It is simply not accepted until IDLE.
- Outputs in_ready and out_valid are decoded from the state register only, with no combinational path from in_valid or out_ready.
- Arithmetic: the result equals the low WIDTH bits of the unsigned value a+b+cin, and cout is bit WIDTH of that value.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, busy=0, carry_reg=0, idx=0. Also ovf=0 when the overflow option is compiled in.
- Latency: accept at edge k; RUN occupies cycles k+1..k+NIBBLES; out_valid is high from edge k+NIBBLES.
- Throughput: one result per NIBBLES+2 cycles with out_ready held high (accept, NIBBLES RUN, DONE→IDLE).
- Asserting rst_n low mid-RUN or in DONE aborts immediately. Outputs go to reset values, the result is discarded and no out_valid pulse is produced.
- WIDTH=4: RUN lasts exactly one cycle.

## Configuration
- Macro: LAB3_SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), meaning two's-complement signed overflow.
  - ovf = (carry into bit WIDTH-1) XOR cout.
  - Captured during the final RUN cycle from the slice's internal bit-3 carry. Valid with out_valid, held with sum, reset to 0.
- When undefined: the port is absent and there is no bit-3 carry tap logic.

## Structure
- Shared package/header lab3_defs holds:
  - NIBBLE_W=4.
  - FSM state encodings: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2. 2'd3 is unreachable and decodes to IDLE.
- One sub-module: lab3_nibble_cla.
  - Combinational 4-bit CLA with P/G generate and lookahead carries.
  - Outputs: 4-bit sum, carry out, and bit-3 carry-in for the overflow option.
- FSM, operand registers, index and carry register live in the top.

## Test plan
All scenarios use WIDTH=16.
- 0x1234+0x4321, cin=0, out_ready=1 → out_valid exactly 4 cycles after accept; sum=0x5555, cout=0.
- 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1; the carry ripples through all 4 nibbles.
- 0x0000+0x0000, cin=1 → sum=0x0001, cout=0.
- Backpressure: 0x00FF+0x0001 with out_ready=0 for 5 cycles → out_valid, sum=0x0100 and cout=0 held stable, and in_ready=0 throughout. out_ready=1 → IDLE next cycle and in_ready=1.
- Reset mid-op: accept 0xAAAA+0x5555, then drop rst_n in the 2nd RUN cycle → sum=0, out_valid never asserts, in_ready=1 after release. A new 0x0001+0x0001 → 0x0002.
- With LAB3_SERIAL_ADDER_OVF_EN defined:
  - 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1.
  - 0xFFFF+0x0001 → ovf=0.
